// File: rtl/dcm_reset_sequencer_if.sv
// Bundle between the reset sequencer and the DCM_SP plus downstream reset consumers.
// master = sequencer side, slave = DCM / system side.
interface dcm_reset_sequencer_if;
  logic       LOCKED;
  logic [7:0] STATUS;
  logic       DCM_RST;
  logic       SYS_RST;
  logic       READY;
  logic       FAILED;
  logic [7:0] RETRY_CNT;

  modport master (
    input  LOCKED,
    input  STATUS,
    output DCM_RST,
    output SYS_RST,
    output READY,
    output FAILED,
    output RETRY_CNT
  );

  modport slave (
    output LOCKED,
    output STATUS,
    input  DCM_RST,
    input  SYS_RST,
    input  READY,
    input  FAILED,
    input  RETRY_CNT
  );
endinterface

// File: rtl/dcm_reset_sequencer.sv
// DCM_SP reset/lock sequencer on CLKIN: pulses DCM RST, waits for lock, settles, then releases system reset.
// Optional macro DCM_STATUS_MON_EN adds STATUS[2] (CLKFX stopped) monitoring in SETTLE and RUN.
module dcm_reset_sequencer #(
  parameter int DCM_RST_CYCLES = 3,
  parameter int LOCK_TIMEOUT   = 1024,
  parameter int SETTLE_CYCLES  = 16,
  parameter int MAX_RETRIES    = 0
) (
  input  logic                  CLKIN,
  input  logic                  RST,
  dcm_reset_sequencer_if.master bus
);

  localparam int MAX_AB = (LOCK_TIMEOUT > SETTLE_CYCLES) ? LOCK_TIMEOUT : SETTLE_CYCLES;
  localparam int MAX_N  = (MAX_AB > DCM_RST_CYCLES) ? MAX_AB : DCM_RST_CYCLES;
  localparam int CW     = $clog2(MAX_N) + 1;

  localparam logic [CW-1:0] RST_LAST     = CW'(DCM_RST_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
  localparam logic [7:0]    RETRY_LIMIT  = 8'(MAX_RETRIES);

  typedef enum logic [2:0] {
    RESET_DCM = 3'd0,
    WAIT_LOCK = 3'd1,
    SETTLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [7:0]    retry_reg, retry_next;

  logic dcm_rst_reg, dcm_rst_next;
  logic sys_rst_reg, sys_rst_next;
  logic ready_reg, ready_next;
  logic failed_reg, failed_next;

  logic lock_meta_reg;
  logic lock_s_reg;
  logic lock_s;
  logic lock_ok;

  // LOCKED comes from the DCM with no timing relationship to CLKIN.
  always_ff @(posedge CLKIN or posedge RST) begin
    if (RST) begin
      lock_meta_reg <= 1'b0;
      lock_s_reg    <= 1'b0;
    end else begin
      lock_meta_reg <= bus.LOCKED;
      lock_s_reg    <= lock_meta_reg;
    end
  end

  assign lock_s = lock_s_reg;

`ifdef DCM_STATUS_MON_EN
  logic fx_stop_meta_reg;
  logic fx_stop_s_reg;
  logic unused_status;

  always_ff @(posedge CLKIN or posedge RST) begin
    if (RST) begin
      fx_stop_meta_reg <= 1'b0;
      fx_stop_s_reg    <= 1'b0;
    end else begin
      fx_stop_meta_reg <= bus.STATUS[2];
      fx_stop_s_reg    <= fx_stop_meta_reg;
    end
  end

  // A stopped CLKFX is as bad as lost lock once we are past WAIT_LOCK.
  assign lock_ok       = lock_s & ~fx_stop_s_reg;
  assign unused_status = ^{bus.STATUS[7:3], bus.STATUS[1:0]};
`else
  logic unused_status;

  assign lock_ok       = lock_s;
  assign unused_status = ^bus.STATUS;
`endif

  always_ff @(posedge CLKIN or posedge RST) begin
    if (RST) begin
      state_reg   <= RESET_DCM;
      cnt_reg     <= '0;
      retry_reg   <= 8'd0;
      dcm_rst_reg <= 1'b1;
      sys_rst_reg <= 1'b1;
      ready_reg   <= 1'b0;
      failed_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      retry_reg   <= retry_next;
      dcm_rst_reg <= dcm_rst_next;
      sys_rst_reg <= sys_rst_next;
      ready_reg   <= ready_next;
      failed_reg  <= failed_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    retry_next = retry_reg;

    case (state_reg)
      RESET_DCM: begin
        if (cnt_reg == RST_LAST) begin
          state_next = WAIT_LOCK;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      WAIT_LOCK: begin
        // Lock has priority over a timeout on the same edge.
        if (lock_s) begin
          state_next = SETTLE;
          cnt_next   = '0;
        end else if (cnt_reg == TIMEOUT_LAST) begin
          cnt_next = '0;
          if ((MAX_RETRIES != 0) && (retry_reg == RETRY_LIMIT)) begin
            state_next = FAIL;
          end else begin
            state_next = RESET_DCM;
            if (retry_reg != 8'hFF) begin
              retry_next = retry_reg + 8'd1;
            end
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      SETTLE: begin
        if (!lock_ok) begin
          state_next = WAIT_LOCK;
          cnt_next   = '0;
        end else if (cnt_reg == SETTLE_LAST) begin
          state_next = RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      RUN: begin
        if (!lock_ok) begin
          state_next = RESET_DCM;
          cnt_next   = '0;
        end
      end

      FAIL: begin
        state_next = FAIL;
      end

      default: begin
        state_next = RESET_DCM;
        cnt_next   = '0;
      end
    endcase

    // Outputs are decoded from the next state so every pin comes straight off a flop.
    dcm_rst_next = (state_next == RESET_DCM);
    sys_rst_next = (state_next != RUN);
    ready_next   = (state_next == RUN);
    failed_next  = (state_next == FAIL);
  end

  assign bus.DCM_RST   = dcm_rst_reg;
  assign bus.SYS_RST   = sys_rst_reg;
  assign bus.READY     = ready_reg;
  assign bus.FAILED    = failed_reg;
  assign bus.RETRY_CNT = retry_reg;

endmodule

// File: tb/tb_dcm_reset_sequencer.sv
// Scoreboard bench for dcm_reset_sequencer: expected output words are queued with the edge
// at which they must appear and compared on the following falling edge.
module tb_dcm_reset_sequencer;

  localparam int DCM_RST_CYCLES = 3;
  localparam int LOCK_TIMEOUT   = 64;
  localparam int SETTLE_CYCLES  = 4;
  localparam int MAX_RETRIES    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  dcm_reset_sequencer_if dcm_bus ();

  dcm_reset_sequencer #(
    .DCM_RST_CYCLES (DCM_RST_CYCLES),
    .LOCK_TIMEOUT   (LOCK_TIMEOUT),
    .SETTLE_CYCLES  (SETTLE_CYCLES),
    .MAX_RETRIES    (MAX_RETRIES)
  ) dut (
    .CLKIN (clk),
    .RST   (rst),
    .bus   (dcm_bus.master)
  );

  // {DCM_RST, SYS_RST, READY, FAILED, RETRY_CNT[7:0]}
  logic [11:0] obs_vec;
  assign obs_vec = {dcm_bus.DCM_RST, dcm_bus.SYS_RST, dcm_bus.READY,
                    dcm_bus.FAILED, dcm_bus.RETRY_CNT};

  typedef struct {
    string       tag;
    int          at;
    logic [11:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   edges        = 0;
  int   n_compared   = 0;
  int   n_mismatched = 0;

  always @(posedge clk) edges++;

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s @edge %0d: got dcm/sys/rdy/fail=%b rc=%0d, expected dcm/sys/rdy/fail=%b rc=%0d",
               tag, edges, got[11:8], got[7:0], exp[11:8], exp[7:0]);
    end else begin
      $display("ok   %s @edge %0d: dcm/sys/rdy/fail=%b rc=%0d", tag, edges, got[11:8], got[7:0]);
    end
  endtask

  task automatic sb_push(input string tag, input int rel, input logic d, input logic s,
                         input logic r, input logic f, input logic [7:0] rc);
    exp_t e;
    e.tag = tag;
    e.at  = edges + rel;
    e.val = {d, s, r, f, rc};
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].at == edges) begin
        check(sb_q[i].tag, obs_vec, sb_q[i].val);
        sb_q.delete(i);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drain(input int budget);
    int left;
    left = budget;
    while (sb_q.size() != 0 && left > 0) begin
      @(posedge clk);
      left--;
    end
    #2;
    if (sb_q.size() != 0) begin
      check("drain_timeout", 12'(sb_q.size()), 12'd0);
      sb_q.delete();
    end
  endtask

  // Pulse RST, check the asynchronous reset values, release, and queue the DCM_RST pulse shape.
  task automatic reset_and_release(input string tag);
    step(1);
    rst = 1'b1;
    #1;
    check({tag, "_rst_async"}, obs_vec, 12'hC00);
    step(2);
    check({tag, "_rst_hold"}, obs_vec, 12'hC00);
    rst = 1'b0;
    sb_push({tag, "_dcmrst_e1"}, 1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    sb_push({tag, "_dcmrst_e2"}, 2, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    sb_push({tag, "_dcmrst_e3"}, 3, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
  endtask

  initial begin
    dcm_bus.LOCKED = 1'b0;
    dcm_bus.STATUS = 8'h00;
    rst            = 1'b1;
    repeat (3) @(posedge clk);

    // Reset release, then lock 10 cycles after DCM_RST falls.
    reset_and_release("boot");
    step(13);
    dcm_bus.LOCKED = 1'b1;
    sb_push("lock_settling", 6, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    sb_push("lock_ready",    7, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    drain(100);

    // Lock loss in RUN, then relock.
    step(2);
    dcm_bus.LOCKED = 1'b0;
    sb_push("loss_still_run", 2, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    sb_push("loss_reset",     3, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    sb_push("loss_dcmrst_e3", 5, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    sb_push("loss_dcmrst_end",6, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    drain(100);
    step(1);
    dcm_bus.LOCKED = 1'b1;
    sb_push("relock_settling", 6, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    sb_push("relock_ready",    7, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    drain(100);

    // STATUS[2] in RUN.
    step(2);
    dcm_bus.STATUS = 8'h04;
`ifdef DCM_STATUS_MON_EN
    sb_push("fxstop_still_run", 2, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    sb_push("fxstop_reset",     3, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
`else
    sb_push("fxstop_ignored_e3", 3, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    sb_push("fxstop_ignored_e8", 8, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
`endif
    drain(100);
    dcm_bus.STATUS = 8'h00;

    // One-cycle LOCKED glitch during the third SETTLE cycle.
    dcm_bus.LOCKED = 1'b0;
    reset_and_release("glitch");
    step(3);
    dcm_bus.LOCKED = 1'b1;
    sb_push("glitch_back_to_wait", 6,  1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    sb_push("glitch_settling",     10, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    sb_push("glitch_ready",        11, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    step(3);
    dcm_bus.LOCKED = 1'b0;
    step(1);
    dcm_bus.LOCKED = 1'b1;
    drain(100);

    // RST asserted mid-SETTLE.
    dcm_bus.LOCKED = 1'b0;
    reset_and_release("midsettle");
    step(3);
    dcm_bus.LOCKED = 1'b1;
    step(4);
    #1;
    rst = 1'b1;
    #1;
    check("rst_mid_settle", obs_vec, 12'hC00);
    step(2);
    check("rst_mid_settle_hold", obs_vec, 12'hC00);

    // LOCKED never rises: two retries, third timeout is fatal.
    dcm_bus.LOCKED = 1'b0;
    reset_and_release("retry");
    sb_push("retry1_pre",    66,  1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    sb_push("retry1_pulse",  67,  1'b1, 1'b1, 1'b0, 1'b0, 8'd1);
    sb_push("retry1_e3",     69,  1'b1, 1'b1, 1'b0, 1'b0, 8'd1);
    sb_push("retry1_wait",   70,  1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
    sb_push("retry2_pre",    133, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
    sb_push("retry2_pulse",  134, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2);
    sb_push("retry2_wait",   137, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2);
    sb_push("fail_pre",      200, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2);
    sb_push("fail_enter",    201, 1'b0, 1'b1, 1'b0, 1'b1, 8'd2);
    sb_push("fail_sticky",   230, 1'b0, 1'b1, 1'b0, 1'b1, 8'd2);
    drain(400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
